serv_decode_q: RTL and testbench
================================

# serv_decode_q

Queued, parametrised instruction decoder for SERV. It accepts fetched instruction words from the ibus side into a DEPTH-entry queue and presents one registered, decoded control set at a time to state/ctrl/alu/bufreg/mem/csr under a valid/ready handshake. It generalises the single-register decoder with three additions: instruction buffering, a flush path, and a FULL mode that enables shift/CSR/trap decode. It also adds illegal-opcode detection.

## Interface
- DEPTH, 2: queue entries, power of 2, ≥1.
- FULL, 1: 1 decodes shift, ebreak, mret and CSR fields; 0 forces those outputs to 0.
- clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-high; clears all state.
- i_wb_rdt  in  30  instruction bits [31:2].
- i_wb_en  in  1  push request.
- o_full  out  1  queue count == DEPTH, combinational from count.
- o_ovf  out  1  sticky; set when push is dropped because the queue is full.
- o_count  out  clog2(DEPTH+1)  queue occupancy (excludes decode register).
- i_flush  in  1  discard queue and decode register.
- o_dec_valid  out  1  decoded outputs hold a live instruction.
- i_dec_rdy  in  1  consumer takes the current decoded instruction.
- Decoded outputs (all 1 bit unless noted):
  - o_branch_op, o_mem_op, o_mem_cmd, o_rd_op, o_alu_sub, o_alu_rd_sel[2:0], o_op_b_source, o_ctrl_utype, o_ctrl_jal_or_jalr, o_slt_op, o_e_op, o_illegal
  - FULL-gated: o_shift_op, o_sh_right, o_ebreak, o_ctrl_mret, o_csr_en, o_rd_csr_en

## Operation
- Field definitions:
  - op = instr[6:2], f3 = instr[14:12].
  - i30, b20, b21, b26 = instr bits 30, 20, 21, 26.
  - Derived terms: sys = op[4]&op[2]; opx = !op[4]&op[2]&!op[0]; csr = sys & |f3.
- Decode equations:
  - branch_op = op[4]&!op[2]
  - mem_op = !op[4]&!op[2]&!op[0]
  - mem_cmd = op[3]
  - rd_op = op[2] | (op[4]&op[0]) | (!op[3]&!op[0])
  - alu_sub = f3[1] | f3[0] | (op[3]&i30) | op[4]
  - alu_rd_sel = {f3[2], f3[2:1]==01, f3==000}
  - op_b_source = op[3]
  - ctrl_utype = !op[4]&op[2]&op[0]
  - ctrl_jal_or_jalr = op[4]&op[0]
  - slt_op = opx & f3[2:1]==01
  - e_op = sys & !b21 & f3==0
- FULL=1 equations (FULL=0 forces each to 0):
  - shift_op = opx & f3[1:0]==01
  - sh_right = f3[2]
  - ebreak = b20
  - ctrl_mret = sys & b21 & f3==0
  - rd_csr_en = csr
  - csr_en = csr & (b20 | (b26&!b21))
- o_illegal = 1 unless op ∈ {00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100}.
- Queue: circular buffer with rd/wr pointers wrapping DEPTH-1→0; count tracks occupancy.
- Decode-register load condition: load = !o_dec_valid | i_dec_rdy. Priority of source when load is true:
  - Queue non-empty: head is popped, decoded and registered.
  - Queue empty and i_wb_en: bypass; the incoming word is decoded straight into the register and the queue is untouched.
  - Otherwise: o_dec_valid is cleared if i_dec_rdy.
- Push into the queue happens when i_wb_en, not bypassed, and !o_full. If the queue is full, the push is dropped even if a pop occurs the same cycle, and o_ovf is set.
- Simultaneous push and pop with a non-full queue: count unchanged, FIFO order preserved.
- i_flush has highest priority:
  - Next edge: count=0, pointers=0, o_dec_valid=0.
  - A same-cycle push is discarded.
  - Decoded outputs retain their values.
  - o_ovf is unaffected.
- Decoded outputs change only on a load edge and are stable while o_dec_valid & !i_dec_rdy.

## Timing
- Reset: every output 0, including o_dec_valid, o_ovf and o_count; pointers 0. Asynchronous assert; release is sampled on the first edge after deassert.
- Bypass latency: word pushed at edge N is decoded and valid after edge N.
- Queued latency: head reaches outputs on the first edge where load is true.
- Throughput: one instruction per cycle with i_dec_rdy held high.
- o_full and o_count update on the edge after the causing push/pop.
- Reset mid-stream: queue contents are lost; no spurious o_dec_valid after release.

## Test plan
- Reset, then push ADD 0x003100B3 (i_wb_rdt = instr>>2) with queue empty:
  - After 1 edge: o_dec_valid=1, o_rd_op=1, o_alu_sub=0, o_alu_rd_sel=001, o_op_b_source=1, o_illegal=0.
- Hold i_dec_rdy=0 and push SUB 0x403100B3, BEQ 0x00208463, plus one more (DEPTH=2):
  - Queue accepts SUB and BEQ; count=2, o_full=1.
  - Third push is dropped; o_ovf=1.
  - Raising i_dec_rdy yields SUB (alu_sub=1), then BEQ (branch_op=1, rd_op=0), in order.
- csrrw 0x340110F3:
  - FULL=1: o_rd_csr_en=1, o_csr_en=1.
  - FULL=0: both 0, and o_shift_op, o_ctrl_mret, o_ebreak also 0.
- Push 0x0000007F (op=11111): o_illegal=1. MRET 0x30200073 with FULL=1: o_ctrl_mret=1, o_e_op=0.
- Queue holds 2 with o_dec_valid=1; assert i_flush together with i_wb_en:
  - Next cycle: count=0, o_dec_valid=0, pushed word absent.
- Assert i_rst mid-burst: outputs go to 0 immediately (asynchronous). After release, first push bypasses with 1-edge latency.

Source files
------------

// File: rtl/serv_decode_q.sv
// Queued SERV instruction decoder: buffers fetched words in a DEPTH-entry ring and
// presents one registered decoded control set at a time under a valid/ready handshake.
module serv_decode_q #(
   parameter int DEPTH = 2,
   parameter bit FULL  = 1'b1
) (
   input  logic                         clk,
   input  logic                         i_rst,
   input  logic [29:0]                  i_wb_rdt,
   input  logic                         i_wb_en,
   output logic                         o_full,
   output logic                         o_ovf,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   input  logic                         i_flush,
   output logic                         o_dec_valid,
   input  logic                         i_dec_rdy,
   output logic                         o_branch_op,
   output logic                         o_mem_op,
   output logic                         o_mem_cmd,
   output logic                         o_rd_op,
   output logic                         o_alu_sub,
   output logic [2:0]                   o_alu_rd_sel,
   output logic                         o_op_b_source,
   output logic                         o_ctrl_utype,
   output logic                         o_ctrl_jal_or_jalr,
   output logic                         o_slt_op,
   output logic                         o_e_op,
   output logic                         o_illegal,
   output logic                         o_shift_op,
   output logic                         o_sh_right,
   output logic                         o_ebreak,
   output logic                         o_ctrl_mret,
   output logic                         o_csr_en,
   output logic                         o_rd_csr_en
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Only the instruction bits the decoder looks at are kept in the queue.
   typedef struct packed {
      logic [4:0] op;
      logic [2:0] f3;
      logic       i30;
      logic       b20;
      logic       b21;
      logic       b26;
   } fld_t;

   typedef struct packed {
      logic       branch_op;
      logic       mem_op;
      logic       mem_cmd;
      logic       rd_op;
      logic       alu_sub;
      logic [2:0] alu_rd_sel;
      logic       op_b_source;
      logic       ctrl_utype;
      logic       ctrl_jal_or_jalr;
      logic       slt_op;
      logic       e_op;
      logic       illegal;
      logic       shift_op;
      logic       sh_right;
      logic       ebreak;
      logic       ctrl_mret;
      logic       csr_en;
      logic       rd_csr_en;
   } dec_t;

   function automatic dec_t decode(input fld_t f);
      dec_t d;
      logic sys, opx, csr;
      sys = f.op[4] & f.op[2];
      opx = !f.op[4] & f.op[2] & !f.op[0];
      csr = sys & (|f.f3);
      d = '0;
      d.branch_op        = f.op[4] & !f.op[2];
      d.mem_op           = !f.op[4] & !f.op[2] & !f.op[0];
      d.mem_cmd          = f.op[3];
      d.rd_op            = f.op[2] | (f.op[4] & f.op[0]) | (!f.op[3] & !f.op[0]);
      d.alu_sub          = f.f3[1] | f.f3[0] | (f.op[3] & f.i30) | f.op[4];
      d.alu_rd_sel       = {f.f3[2], f.f3[2:1] == 2'b01, f.f3 == 3'b000};
      d.op_b_source      = f.op[3];
      d.ctrl_utype       = !f.op[4] & f.op[2] & f.op[0];
      d.ctrl_jal_or_jalr = f.op[4] & f.op[0];
      d.slt_op           = opx & (f.f3[2:1] == 2'b01);
      d.e_op             = sys & !f.b21 & (f.f3 == 3'b000);
      case (f.op)
         5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
         5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: d.illegal = 1'b0;
         default:                                          d.illegal = 1'b1;
      endcase
      if (FULL) begin
         d.shift_op  = opx & (f.f3[1:0] == 2'b01);
         d.sh_right  = f.f3[2];
         d.ebreak    = f.b20;
         d.ctrl_mret = sys & f.b21 & (f.f3 == 3'b000);
         d.rd_csr_en = csr;
         d.csr_en    = csr & (f.b20 | (f.b26 & !f.b21));
      end
      return d;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   fld_t            mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d, valid_q, valid_d;
   dec_t            dec_q, dec_d;
   fld_t            in_f;
   logic            full, empty, load, pop, bypass, push, drop;
   logic            unused_rdt;

   assign in_f = '{op: i_wb_rdt[4:0], f3: i_wb_rdt[12:10], i30: i_wb_rdt[28],
                   b20: i_wb_rdt[18], b21: i_wb_rdt[19], b26: i_wb_rdt[24]};
   assign unused_rdt = ^{i_wb_rdt[29], i_wb_rdt[27:25], i_wb_rdt[23:20],
                         i_wb_rdt[17:13], i_wb_rdt[9:5]};

   // Handshake: the decode register holds a live instruction while o_dec_valid is high;
   // it is replaced (or emptied) on any edge where !o_dec_valid | i_dec_rdy.
   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   assign load   = !valid_q | i_dec_rdy;
   assign pop    = !i_flush & load & !empty;
   assign bypass = !i_flush & load & empty & i_wb_en;
   assign push   = !i_flush & i_wb_en & !bypass & !full;
   assign drop   = !i_flush & i_wb_en & !bypass & full;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | drop;
      valid_d  = valid_q;
      dec_d    = dec_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         valid_d  = 1'b0;
      end else begin
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
         if (load) valid_d = pop | bypass;
         if (pop)         dec_d = decode(mem_q[rd_ptr_q]);
         else if (bypass) dec_d = decode(in_f);
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         dec_q    <= '0;
      end else begin
         if (push) mem_q[wr_ptr_q] <= in_f;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         dec_q    <= dec_d;
      end
   end

   assign o_full             = full;
   assign o_ovf              = ovf_q;
   assign o_count            = count_q;
   assign o_dec_valid        = valid_q;
   assign o_branch_op        = dec_q.branch_op;
   assign o_mem_op           = dec_q.mem_op;
   assign o_mem_cmd          = dec_q.mem_cmd;
   assign o_rd_op            = dec_q.rd_op;
   assign o_alu_sub          = dec_q.alu_sub;
   assign o_alu_rd_sel       = dec_q.alu_rd_sel;
   assign o_op_b_source      = dec_q.op_b_source;
   assign o_ctrl_utype       = dec_q.ctrl_utype;
   assign o_ctrl_jal_or_jalr = dec_q.ctrl_jal_or_jalr;
   assign o_slt_op           = dec_q.slt_op;
   assign o_e_op             = dec_q.e_op;
   assign o_illegal          = dec_q.illegal;
   assign o_shift_op         = dec_q.shift_op;
   assign o_sh_right         = dec_q.sh_right;
   assign o_ebreak           = dec_q.ebreak;
   assign o_ctrl_mret        = dec_q.ctrl_mret;
   assign o_csr_en           = dec_q.csr_en;
   assign o_rd_csr_en        = dec_q.rd_csr_en;
endmodule

// File: tb/tb_serv_decode_q.sv
// Bench for serv_decode_q: two instances (FULL=1 and FULL=0) driven in lockstep and
// compared every cycle against a queue-based reference model of the decoder.
module tb_serv_decode_q;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en, flush, rdy;
   logic [29:0] rdt;

   wire         full_a, ovf_a, valid_a, full_b, ovf_b, valid_b;
   wire [1:0]   cnt_a, cnt_b;
   // Packed decode bits: 19 branch,18 mem_op,17 mem_cmd,16 rd_op,15 alu_sub,14:12 alu_rd_sel,
   // 11 op_b,10 utype,9 jal,8 slt,7 e_op,6 illegal,5 shift,4 sh_right,3 ebreak,2 mret,1 csr_en,0 rd_csr_en
   wire [19:0]  dec_a, dec_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serv_decode_q #(.DEPTH(DEPTH), .FULL(1'b1)) u_full (
      .clk(clk), .i_rst(rst), .i_wb_rdt(rdt), .i_wb_en(wb_en), .o_full(full_a),
      .o_ovf(ovf_a), .o_count(cnt_a), .i_flush(flush), .o_dec_valid(valid_a),
      .i_dec_rdy(rdy), .o_branch_op(dec_a[19]), .o_mem_op(dec_a[18]),
      .o_mem_cmd(dec_a[17]), .o_rd_op(dec_a[16]), .o_alu_sub(dec_a[15]),
      .o_alu_rd_sel(dec_a[14:12]), .o_op_b_source(dec_a[11]), .o_ctrl_utype(dec_a[10]),
      .o_ctrl_jal_or_jalr(dec_a[9]), .o_slt_op(dec_a[8]), .o_e_op(dec_a[7]),
      .o_illegal(dec_a[6]), .o_shift_op(dec_a[5]), .o_sh_right(dec_a[4]),
      .o_ebreak(dec_a[3]), .o_ctrl_mret(dec_a[2]), .o_csr_en(dec_a[1]),
      .o_rd_csr_en(dec_a[0])
   );

   serv_decode_q #(.DEPTH(DEPTH), .FULL(1'b0)) u_lite (
      .clk(clk), .i_rst(rst), .i_wb_rdt(rdt), .i_wb_en(wb_en), .o_full(full_b),
      .o_ovf(ovf_b), .o_count(cnt_b), .i_flush(flush), .o_dec_valid(valid_b),
      .i_dec_rdy(rdy), .o_branch_op(dec_b[19]), .o_mem_op(dec_b[18]),
      .o_mem_cmd(dec_b[17]), .o_rd_op(dec_b[16]), .o_alu_sub(dec_b[15]),
      .o_alu_rd_sel(dec_b[14:12]), .o_op_b_source(dec_b[11]), .o_ctrl_utype(dec_b[10]),
      .o_ctrl_jal_or_jalr(dec_b[9]), .o_slt_op(dec_b[8]), .o_e_op(dec_b[7]),
      .o_illegal(dec_b[6]), .o_shift_op(dec_b[5]), .o_sh_right(dec_b[4]),
      .o_ebreak(dec_b[3]), .o_ctrl_mret(dec_b[2]), .o_csr_en(dec_b[1]),
      .o_rd_csr_en(dec_b[0])
   );

   // Reference model state
   logic [29:0] mq[$];
   bit          m_valid;
   bit          m_ovf;
   logic [19:0] exp_a, exp_b;
   logic [4:0]  legal_ops [11] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C,
                                   5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};

   function automatic logic [19:0] ref_dec(input logic [31:0] ins, input bit full);
      logic [4:0]  op;
      logic [2:0]  f3;
      bit          sys, opx, csr, legal;
      logic [19:0] r;
      op  = ins[6:2];
      f3  = ins[14:12];
      sys = op[4] && op[2];
      opx = !op[4] && op[2] && !op[0];
      csr = sys && (f3 != 3'd0);
      legal = 1'b0;
      foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
      r = '0;
      r[19] = op[4] && !op[2];
      r[18] = !op[4] && !op[2] && !op[0];
      r[17] = op[3];
      r[16] = op[2] || (op[4] && op[0]) || (!op[3] && !op[0]);
      r[15] = (f3[1:0] != 2'd0) || (op[3] && ins[30]) || op[4];
      r[14] = f3[2];
      r[13] = (f3[2:1] == 2'b01);
      r[12] = (f3 == 3'd0);
      r[11] = op[3];
      r[10] = !op[4] && op[2] && op[0];
      r[9]  = op[4] && op[0];
      r[8]  = opx && (f3[2:1] == 2'b01);
      r[7]  = sys && !ins[21] && (f3 == 3'd0);
      r[6]  = !legal;
      if (full) begin
         r[5] = opx && (f3[1:0] == 2'b01);
         r[4] = f3[2];
         r[3] = ins[20];
         r[2] = sys && ins[21] && (f3 == 3'd0);
         r[1] = csr && (ins[20] || (ins[26] && !ins[21]));
         r[0] = csr;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, "_valid_a"}, 32'(valid_a), 32'(m_valid));
      chk({tag, "_count_a"}, 32'(cnt_a), 32'(mq.size()));
      chk({tag, "_full_a"},  32'(full_a), 32'(mq.size() == DEPTH));
      chk({tag, "_ovf_a"},   32'(ovf_a), 32'(m_ovf));
      chk({tag, "_dec_a"},   32'(dec_a), 32'(exp_a));
      chk({tag, "_valid_b"}, 32'(valid_b), 32'(m_valid));
      chk({tag, "_count_b"}, 32'(cnt_b), 32'(mq.size()));
      chk({tag, "_dec_b"},   32'(dec_b), 32'(exp_b));
   endtask

   task automatic model_load(input logic [29:0] w);
      exp_a = ref_dec({w, 2'b11}, 1'b1);
      exp_b = ref_dec({w, 2'b11}, 1'b0);
      m_valid = 1'b1;
   endtask

   // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
   task automatic step(input bit en, input logic [29:0] w, input bit r, input bit fl,
                       input string tag);
      int  n;
      bit  ld, byp;
      @(negedge clk);
      wb_en = en; rdt = w; rdy = r; flush = fl;
      @(posedge clk);
      n   = mq.size();
      ld  = !m_valid || r;
      byp = 1'b0;
      if (fl) begin
         mq.delete();
         m_valid = 1'b0;
      end else begin
         if (ld && n > 0) model_load(mq.pop_front());
         else if (ld && en) begin
            model_load(w);
            byp = 1'b1;
         end else if (ld) m_valid = 1'b0;
         if (en && !byp) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else mq.push_back(w);
         end
      end
      #1;
      compare_all(tag);
   endtask

   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #1;
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      exp_a   = '0;
      exp_b   = '0;
      compare_all(tag);
      wb_en = 1'b0; flush = 1'b0; rdy = 1'b0; rdt = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   localparam logic [31:0] I_ADD   = 32'h003100B3;
   localparam logic [31:0] I_SUB   = 32'h403100B3;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_CSRRW = 32'h340110F3;
   localparam logic [31:0] I_ILL   = 32'h0000007F;
   localparam logic [31:0] I_MRET  = 32'h30200073;

   initial begin
      logic [29:0] w;
      bit          en, r, fl;
      wb_en = 1'b0; flush = 1'b0; rdy = 1'b0; rdt = '0;

      apply_reset("reset");

      // Bypass with empty queue
      step(1'b1, 30'(I_ADD >> 2), 1'b0, 1'b0, "add");
      chk("add_valid", 32'(valid_a), 32'd1);
      chk("add_rd_op", 32'(dec_a[16]), 32'd1);
      chk("add_alu_sub", 32'(dec_a[15]), 32'd0);
      chk("add_alu_rd_sel", 32'(dec_a[14:12]), 32'b001);
      chk("add_op_b", 32'(dec_a[11]), 32'd1);
      chk("add_illegal", 32'(dec_a[6]), 32'd0);

      // Fill queue while stalled, then overflow
      step(1'b1, 30'(I_SUB >> 2), 1'b0, 1'b0, "push_sub");
      step(1'b1, 30'(I_BEQ >> 2), 1'b0, 1'b0, "push_beq");
      chk("fill_count", 32'(cnt_a), 32'd2);
      chk("fill_full", 32'(full_a), 32'd1);
      chk("fill_ovf_clear", 32'(ovf_a), 32'd0);
      step(1'b1, 30'(I_ILL >> 2), 1'b0, 1'b0, "push_drop");
      chk("drop_ovf", 32'(ovf_a), 32'd1);
      chk("drop_count", 32'(cnt_a), 32'd2);
      chk("stall_held_add", 32'(dec_a[15]), 32'd0);

      // Drain in order
      step(1'b0, '0, 1'b1, 1'b0, "pop_sub");
      chk("sub_alu_sub", 32'(dec_a[15]), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0, "pop_beq");
      chk("beq_branch", 32'(dec_a[19]), 32'd1);
      chk("beq_rd_op", 32'(dec_a[16]), 32'd0);
      step(1'b0, '0, 1'b1, 1'b0, "drain_empty");
      chk("drain_valid", 32'(valid_a), 32'd0);

      // CSR, FULL gating, illegal, MRET
      step(1'b1, 30'(I_CSRRW >> 2), 1'b1, 1'b0, "csrrw");
      chk("csr_rd_csr_en_full", 32'(dec_a[0]), 32'd1);
      chk("csr_csr_en_full", 32'(dec_a[1]), 32'd1);
      chk("csr_gated_lite", 32'(dec_b[5:0]), 32'd0);
      step(1'b1, 30'(I_ILL >> 2), 1'b1, 1'b0, "illegal");
      chk("ill_illegal", 32'(dec_a[6]), 32'd1);
      step(1'b1, 30'(I_MRET >> 2), 1'b1, 1'b0, "mret");
      chk("mret_full", 32'(dec_a[2]), 32'd1);
      chk("mret_e_op", 32'(dec_a[7]), 32'd0);
      chk("mret_lite", 32'(dec_b[2]), 32'd0);

      // Flush with a same-cycle push
      step(1'b1, 30'(I_ADD >> 2), 1'b0, 1'b0, "pre_flush1");
      step(1'b1, 30'(I_SUB >> 2), 1'b0, 1'b0, "pre_flush2");
      step(1'b1, 30'(I_BEQ >> 2), 1'b0, 1'b1, "flush");
      chk("flush_count", 32'(cnt_a), 32'd0);
      chk("flush_valid", 32'(valid_a), 32'd0);
      chk("flush_keeps_mret", 32'(dec_a[2]), 32'd1);
      step(1'b0, '0, 1'b1, 1'b0, "post_flush");
      chk("post_flush_valid", 32'(valid_a), 32'd0);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         w = 30'($urandom);
         if ($urandom_range(0, 1) == 0) w[4:0] = legal_ops[$urandom_range(0, 10)];
         en = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 31) == 0);
         step(en, w, r, fl, "rand");
      end

      // Asynchronous reset mid-burst
      step(1'b1, 30'(I_SUB >> 2), 1'b0, 1'b0, "burst1");
      step(1'b1, 30'(I_BEQ >> 2), 1'b0, 1'b0, "burst2");
      @(negedge clk);
      #2;
      apply_reset("midreset");
      step(1'b0, '0, 1'b1, 1'b0, "post_reset_idle");
      chk("post_reset_no_valid", 32'(valid_a), 32'd0);
      step(1'b1, 30'(I_ADD >> 2), 1'b0, 1'b0, "post_reset_add");
      chk("post_reset_bypass", 32'(valid_a), 32'd1);
      chk("post_reset_count", 32'(cnt_a), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
